// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit.
//   - transfer size encodings (Size field)
//   - FSM state encodings
//   - size_to_bytes(): byte count for a Size code
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Size 2'b11 is treated as a word access.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_to_bytes = 3'd1;
            SZ_HALF: size_to_bytes = 3'd2;
            default: size_to_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Bus bundle between the control unit / memory and the memory access unit.
//   Control side : start, write, size, address, wr_data -> unit; rd_data, busy, done <- unit
//   Memory side  : mem_addr, mem_data_out, mem_cs, mem_wr <- unit; mem_data_in -> unit
// The unit uses the slave modport; the environment (control unit plus memory) uses master.
interface mem_access_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  start;
    logic                  write;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           wr_data;
    logic [31:0]           rd_data;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_data_out;
    logic [7:0]            mem_data_in;
    logic                  mem_cs;
    logic                  mem_wr;

    modport slave (
        input  start, write, size, address, wr_data, mem_data_in,
        output rd_data, busy, done, mem_addr, mem_data_out, mem_cs, mem_wr
    );

    modport master (
        output start, write, size, address, wr_data, mem_data_in,
        input  rd_data, busy, done, mem_addr, mem_data_out, mem_cs, mem_wr
    );

endinterface

// File: rtl/mem_read_assembler.sv
// Read-data assembler: tracks which byte lane each read issue belongs to through a
// RD_LATENCY-deep pipeline and drops the returning memory byte into that lane of a
// 32-bit shadow register.
//   clk, rst          clock, async active-high reset
//   clear_i           zero the shadow register (new transfer accepted)
//   issue_valid_i     a read byte is being issued this cycle
//   issue_lane_i      lane index of that issue
//   mem_data_in_i     byte returned by memory
//   shadow_next_o     next-state shadow value, so the top can load a complete word
//                     in the same edge the last byte is captured
module mem_read_assembler #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        issue_valid_i,
    input  logic [1:0]  issue_lane_i,
    input  logic [7:0]  mem_data_in_i,
    output logic [31:0] shadow_next_o
);

    logic [RD_LATENCY-1:0] pipe_valid_q;
    logic [1:0]            pipe_lane_q [RD_LATENCY];
    logic [31:0]           shadow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_lane_q[i] <= '0;
            end
            shadow_q <= '0;
        end else begin
            pipe_valid_q[0] <= issue_valid_i;
            pipe_lane_q[0]  <= issue_lane_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_lane_q[i]  <= pipe_lane_q[i-1];
            end
            shadow_q <= shadow_next_o;
        end
    end

    // The last pipeline stage lines up with the cycle memory presents the byte.
    always_comb begin
        shadow_next_o = shadow_q;
        if (clear_i) begin
            shadow_next_o = '0;
        end else if (pipe_valid_q[RD_LATENCY-1]) begin
            shadow_next_o[{pipe_lane_q[RD_LATENCY-1], 3'b000} +: 8] = mem_data_in_i;
        end
    end

endmodule

// File: rtl/memory_access_unit.sv
// Memory access unit: runs 1/2/4-byte little-endian reads and writes against a
// byte-wide memory, one byte per cycle, with a start/busy/done handshake.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   mem_access_if slave: control handshake plus memory bus, all outputs registered
module memory_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_access_if.slave  bus
);

    localparam logic [1:0] DrainLast = 2'(RD_LATENCY - 1);

    logic [1:0]            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;       // lane of the byte currently on the bus
    logic [1:0]            last_q, last_d;     // N-1
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            drain_q, drain_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cs_q, cs_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [7:0]            mdout_q, mdout_d;
    logic [31:0]           rd_data_q, rd_data_d;

    logic                  clear;
    logic [1:0]            k_next;
    logic [31:0]           shadow_next;

    function automatic logic [31:0] lane_mask(input logic [1:0] last);
        case (last)
            2'd0:    lane_mask = 32'h0000_00ff;
            2'd1:    lane_mask = 32'h0000_ffff;
            default: lane_mask = 32'hffff_ffff;
        endcase
    endfunction

    mem_read_assembler #(
        .RD_LATENCY (RD_LATENCY)
    ) u_assembler (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (clear),
        .issue_valid_i (cs_q & ~wr_q),
        .issue_lane_i  (cnt_q),
        .mem_data_in_i (bus.mem_data_in),
        .shadow_next_o (shadow_next)
    );

    assign k_next = cnt_q + 2'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        write_d   = write_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        drain_d   = drain_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cs_d      = cs_q;
        wr_d      = wr_q;
        maddr_d   = maddr_q;
        mdout_d   = mdout_q;
        rd_data_d = rd_data_q;
        clear     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_XFER;
                    write_d = bus.write;
                    last_d  = 2'(size_to_bytes(bus.size) - 3'd1);
                    base_d  = bus.address;
                    wdata_d = bus.wr_data;
                    cnt_d   = 2'd0;
                    busy_d  = 1'b1;
                    cs_d    = 1'b1;
                    wr_d    = bus.write;
                    maddr_d = bus.address;
                    mdout_d = bus.write ? bus.wr_data[7:0] : 8'h00;
                    clear   = 1'b1;
                end
            end
            ST_XFER: begin
                if (cnt_q == last_q) begin
                    cs_d    = 1'b0;
                    wr_d    = 1'b0;
                    mdout_d = 8'h00;
                    if (write_q) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = 2'd0;
                    end
                end else begin
                    cnt_d   = k_next;
                    maddr_d = base_q + ADDR_WIDTH'(k_next);
                    mdout_d = write_q ? wdata_q[{k_next, 3'b000} +: 8] : 8'h00;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DrainLast) begin
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    // Last byte lands this edge; take the bypassed shadow value.
                    rd_data_d = shadow_next & lane_mask(last_q);
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= '0;
            write_q   <= 1'b0;
            base_q    <= '0;
            wdata_q   <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            maddr_q   <= '0;
            mdout_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            write_q   <= write_d;
            base_q    <= base_d;
            wdata_q   <= wdata_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_q      <= cs_d;
            wr_q      <= wr_d;
            maddr_q   <= maddr_d;
            mdout_q   <= mdout_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.mem_cs       = cs_q;
    assign bus.mem_wr       = wr_q;
    assign bus.mem_addr     = maddr_q;
    assign bus.mem_data_out = mdout_q;
    assign bus.rd_data      = rd_data_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: byte-wide memory with registered read, a transaction-level
// model that schedules the expected output of every cycle, and a per-cycle compare process.
module tb_memory_access_unit;
    import mem_access_pkg::*;

    localparam int RD_LAT = 1;
    localparam int MAXC   = 4096;

    typedef struct {
        bit          act;
        bit          busy;
        bit          done;
        bit          cs;
        bit          wr;
        bit          rd_upd;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_access_if #(.ADDR_WIDTH(16)) ifc ();

    memory_access_unit #(
        .ADDR_WIDTH (16),
        .RD_LATENCY (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    logic [7:0]  mem     [65536];
    logic [7:0]  ref_mem [65536];
    logic [7:0]  mem_rdata = 8'h00;
    exp_t        exp_tab [MAXC];
    exp_t        ce;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          last_done = -1;
    int          cs_cnt = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] cur_rd = 32'h0;

    assign ifc.mem_data_in = mem_rdata;

    // Memory: write on chip-select edge, registered read.
    always @(posedge clk) begin
        if (ifc.mem_cs && ifc.mem_wr) mem[ifc.mem_addr] <= ifc.mem_data_out;
        if (ifc.mem_cs && !ifc.mem_wr) mem_rdata <= mem[ifc.mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic exp_t mk(input bit busy, input bit done, input bit cs, input bit wr,
                                input logic [15:0] addr, input logic [7:0] dout,
                                input bit rd_upd, input logic [31:0] rd);
        exp_t e;
        e.act = 1'b1; e.busy = busy; e.done = done; e.cs = cs; e.wr = wr;
        e.addr = addr; e.dout = dout; e.rd_upd = rd_upd; e.rd = rd;
        return e;
    endfunction

    // Transaction model: first bus cycle is cycle c; only the first 'keep' write bytes
    // are committed to the reference memory.
    function automatic void schedule(input int c, input bit w, input logic [1:0] sz,
                                     input logic [15:0] a, input logic [31:0] wd,
                                     input int keep);
        int          n = nbytes(sz);
        int          dc;
        logic [31:0] rv = 32'h0;
        logic [15:0] ak;
        for (int k = 0; k < n; k++) begin
            ak = a + 16'(k);
            exp_tab[c+k] = mk(1'b1, 1'b0, 1'b1, w, ak, w ? wd[8*k +: 8] : 8'h00, 1'b0, 32'h0);
            if (w && k < keep) ref_mem[ak] = wd[8*k +: 8];
            if (!w) rv[8*k +: 8] = ref_mem[ak];
        end
        if (!w) begin
            for (int d = 0; d < RD_LAT; d++) begin
                exp_tab[c+n+d] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 32'h0);
            end
        end
        dc = c + n + (w ? 0 : RD_LAT);
        exp_tab[dc] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0, !w, rv);
        last_done = dc;
    endfunction

    // Per-cycle compare against the scheduled expectations.
    always @(negedge clk) begin
        if (rst) begin
            cur_rd = 32'h0;
            chk("rst_busy", 32'(ifc.busy), 32'h0);
            chk("rst_done", 32'(ifc.done), 32'h0);
            chk("rst_cs", 32'(ifc.mem_cs), 32'h0);
            chk("rst_wr", 32'(ifc.mem_wr), 32'h0);
            chk("rst_addr", 32'(ifc.mem_addr), 32'h0);
            chk("rst_dout", 32'(ifc.mem_data_out), 32'h0);
            chk("rst_rd", ifc.rd_data, 32'h0);
        end else if (cyc < MAXC) begin
            ce = exp_tab[cyc];
            if (ce.act && ce.rd_upd) cur_rd = ce.rd;
            chk("busy", 32'(ifc.busy), 32'(ce.act && ce.busy));
            chk("done", 32'(ifc.done), 32'(ce.act && ce.done));
            chk("mem_cs", 32'(ifc.mem_cs), 32'(ce.act && ce.cs));
            chk("mem_wr", 32'(ifc.mem_wr), 32'(ce.act && ce.wr));
            if (ce.act && ce.cs) begin
                chk("mem_addr", 32'(ifc.mem_addr), 32'(ce.addr));
                chk("mem_data_out", 32'(ifc.mem_data_out), 32'(ce.dout));
            end
            chk("rd_data", ifc.rd_data, cur_rd);
            cs_cnt   += int'(ifc.mem_cs);
            wr_cnt   += int'(ifc.mem_cs && ifc.mem_wr);
            done_cnt += int'(ifc.done);
        end
    end

    task automatic run_op(input bit w, input logic [1:0] sz, input logic [15:0] a,
                          input logic [31:0] wd, input bit poke,
                          output int done_j, output logic [31:0] rd);
        int t;
        @(negedge clk); #1;
        while (cyc <= last_done) begin
            @(negedge clk); #1;
        end
        ifc.start = 1'b1; ifc.write = w; ifc.size = sz; ifc.address = a; ifc.wr_data = wd;
        t = cyc + 1;
        schedule(t, w, sz, a, wd, 4);
        @(negedge clk); #1;
        // Scramble request inputs after acceptance; they must not matter.
        ifc.write = ~w; ifc.size = 2'($urandom); ifc.address = 16'($urandom);
        ifc.wr_data = $urandom;
        done_j = 0;
        rd = 32'h0;
        for (int j = 1; j <= 20; j++) begin
            if (ifc.done) begin
                done_j = j;
                rd = ifc.rd_data;
                break;
            end
            ifc.start = (poke && j == 2);
            @(negedge clk); #1;
        end
        ifc.start = 1'b0;
        if (done_j == 0) chk("done_timeout", 32'h0, 32'h1);
    endtask

    task automatic chk_mem(input logic [15:0] a);
        chk("mem_contents", 32'(mem[a]), 32'(ref_mem[a]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1);
    end

    initial begin
        int          j;
        int          cs0, wr0, d0, t;
        logic [31:0] rd;
        logic [7:0]  v;
        logic [15:0] ra;

        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        ifc.start = 1'b0; ifc.write = 1'b0; ifc.size = 2'b00;
        ifc.address = 16'h0; ifc.wr_data = 32'h0;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        last_done = cyc;

        // 1: word write
        cs0 = cs_cnt; wr0 = wr_cnt;
        run_op(1'b1, SZ_WORD, 16'h1000, 32'hDEADBEEF, 1'b0, j, rd);
        chk("t1_done_cycle", 32'(j), 32'd5);
        chk("t1_wr_cycles", 32'(wr_cnt - wr0), 32'd4);
        chk("t1_cs_cycles", 32'(cs_cnt - cs0), 32'd4);
        chk("t1_mem1000", 32'(mem[16'h1000]), 32'h0000_00EF);
        chk("t1_mem1001", 32'(mem[16'h1001]), 32'h0000_00BE);
        chk("t1_mem1002", 32'(mem[16'h1002]), 32'h0000_00AD);
        chk("t1_mem1003", 32'(mem[16'h1003]), 32'h0000_00DE);

        // 2: word read back
        run_op(1'b0, SZ_WORD, 16'h1000, 32'h0, 1'b0, j, rd);
        chk("t2_done_cycle", 32'(j), 32'd6);
        chk("t2_rd_data", rd, 32'hDEADBEEF);

        // 3: halfword read wrapping 0xFFFF -> 0x0000
        run_op(1'b1, SZ_BYTE, 16'hFFFF, 32'h0000_0034, 1'b0, j, rd);
        run_op(1'b1, SZ_BYTE, 16'h0000, 32'h0000_0012, 1'b0, j, rd);
        run_op(1'b0, SZ_HALF, 16'hFFFF, 32'h0, 1'b0, j, rd);
        chk("t3_done_cycle", 32'(j), 32'd4);
        chk("t3_rd_data", rd, 32'h0000_1234);

        // 4: start poked while busy is ignored
        cs0 = cs_cnt; d0 = done_cnt;
        run_op(1'b1, SZ_WORD, 16'h1004, 32'h5566_7788, 1'b1, j, rd);
        repeat (3) @(negedge clk);
        #1;
        chk("t4_cs_cycles", 32'(cs_cnt - cs0), 32'd4);
        chk("t4_done_pulses", 32'(done_cnt - d0), 32'd1);

        // 5: reset after two bytes of a word write
        @(negedge clk); #1;
        while (cyc <= last_done) begin
            @(negedge clk); #1;
        end
        d0 = done_cnt;
        ifc.start = 1'b1; ifc.write = 1'b1; ifc.size = SZ_WORD;
        ifc.address = 16'h2000; ifc.wr_data = 32'hA1B2C3D4;
        t = cyc + 1;
        schedule(t, 1'b1, SZ_WORD, 16'h2000, 32'hA1B2C3D4, 2);
        @(negedge clk); #1;
        ifc.start = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        for (int c = t + 3; c < t + 12; c++) exp_tab[c].act = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_cs_clear", 32'(ifc.mem_cs), 32'h0);
        chk("t5_busy_clear", 32'(ifc.busy), 32'h0);
        chk("t5_wr_clear", 32'(ifc.mem_wr), 32'h0);
        chk("t5_rd_clear", ifc.rd_data, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        last_done = cyc;
        repeat (4) @(negedge clk);
        #1;
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t5_mem2000", 32'(mem[16'h2000]), 32'h0000_00D4);
        chk("t5_mem2001", 32'(mem[16'h2001]), 32'h0000_00C3);
        chk_mem(16'h2002);
        chk_mem(16'h2003);

        // 6: byte read, and size 11 behaves as a word
        run_op(1'b1, SZ_BYTE, 16'h3000, 32'hFFFF_FF7F, 1'b0, j, rd);
        run_op(1'b0, SZ_BYTE, 16'h3000, 32'h0, 1'b0, j, rd);
        chk("t6_done_cycle", 32'(j), 32'd3);
        chk("t6_rd_byte", rd, 32'h0000_007F);
        cs0 = cs_cnt;
        run_op(1'b1, 2'b11, 16'h3010, 32'h1122_3344, 1'b0, j, rd);
        chk("t6_size11_cs", 32'(cs_cnt - cs0), 32'd4);
        run_op(1'b0, 2'b11, 16'h3010, 32'h0, 1'b0, j, rd);
        chk("t6_size11_rd", rd, 32'h1122_3344);

        // Random traffic, including starts while busy and back-to-back requests.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            case ($urandom_range(0, 3))
                0:       ra = 16'hFFFC + 16'($urandom_range(0, 7));
                1:       ra = 16'h1000 + 16'($urandom_range(0, 7));
                default: ra = 16'($urandom);
            endcase
            ifc.start   = ($urandom_range(0, 2) == 0) && (cyc + 16 < MAXC);
            ifc.write   = 1'($urandom);
            ifc.size    = 2'($urandom);
            ifc.address = ra;
            ifc.wr_data = $urandom;
            if (ifc.start && cyc > last_done) begin
                schedule(cyc + 1, ifc.write, ifc.size, ra, ifc.wr_data, 4);
            end
        end
        @(negedge clk); #1;
        ifc.start = 1'b0;
        for (int i = 0; i < 20 && cyc <= last_done + 1; i++) begin
            @(negedge clk); #1;
        end

        for (int i = 0; i < 16; i++) chk_mem(16'hFFF8 + 16'(i));
        for (int i = 0; i < 8; i++)  chk_mem(16'h1000 + 16'(i));
        for (int i = 0; i < 4; i++)  chk_mem(16'h2000 + 16'(i));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
